// File: rtl/tree_adder_accum_ctrl_pkg.sv
// Shared types and width helpers for the tree-adder accumulation controller.
package tree_acc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_e;

  // Beat counter must be able to hold MAX_BEATS itself, not just MAX_BEATS-1.
  function automatic int cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

  // Full precision needs P+log2(N) bits; halved mode needs P/2+log2(2N), never more.
  function automatic int tree_sum_w(input int p, input int n);
    return p + $clog2(n);
  endfunction

endpackage

// File: rtl/tree_adder_accum_ctrl_tree.sv
// Combinational binary tree adder over INPUTS_AMOUNT signed lanes; in halved
// precision each lane carries two signed P/2 values that are both summed.
module config_binary_tree_adder
  import tree_acc_pkg::*;
#(
  parameter int P             = 16,
  parameter int INPUTS_AMOUNT = 8
) (
  input  logic [INPUTS_AMOUNT-1:0][P-1:0]                  in_data,
  input  logic                                             halvedPrecision,
  output logic signed [tree_sum_w(P, INPUTS_AMOUNT)-1:0]   sum
);

  localparam int SUM_W = tree_sum_w(P, INPUTS_AMOUNT);
  localparam int LVLS  = $clog2(INPUTS_AMOUNT);
  localparam int HW    = P / 2;

  logic signed [SUM_W-1:0] node [LVLS+1][INPUTS_AMOUNT];

  always_comb begin
    for (int l = 0; l <= LVLS; l++) begin
      for (int i = 0; i < INPUTS_AMOUNT; i++) begin
        node[l][i] = '0;
      end
    end
    // Leaf level: each lane becomes one signed term (halves pre-added).
    for (int i = 0; i < INPUTS_AMOUNT; i++) begin
      if (halvedPrecision) begin
        node[0][i] = SUM_W'(signed'(in_data[i][P-1:HW])) +
                     SUM_W'(signed'(in_data[i][HW-1:0]));
      end else begin
        node[0][i] = SUM_W'(signed'(in_data[i]));
      end
    end
    for (int l = 1; l <= LVLS; l++) begin
      for (int i = 0; i < (INPUTS_AMOUNT >> l); i++) begin
        node[l][i] = node[l-1][2*i] + node[l-1][2*i+1];
      end
    end
  end

  assign sum = node[LVLS][0];

endmodule

// File: rtl/tree_adder_accum_ctrl.sv
// Accepts a configured number of vector beats, reduces each through the tree
// adder, accumulates into a signed register and returns the sum with overflow.
module tree_adder_accum_ctrl
  import tree_acc_pkg::*;
#(
  parameter int P             = 16,
  parameter int INPUTS_AMOUNT = 8,
  parameter int ACC_W         = 32,
  parameter int MAX_BEATS     = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic                              cfg_halved,
  input  logic [cnt_w(MAX_BEATS)-1:0]       cfg_beats,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INPUTS_AMOUNT-1:0][P-1:0]   in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [ACC_W-1:0]           out_data,
  output logic                              out_overflow,
  output logic                              busy
);

  localparam int CNT_W = cnt_w(MAX_BEATS);
  localparam int SUM_W = tree_sum_w(P, INPUTS_AMOUNT);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         beats_q, beats_d;
  logic                     halved_q, halved_d;
  logic                     ovf_q, ovf_d;

  logic signed [SUM_W-1:0]  tree_sum;
  logic signed [ACC_W-1:0]  tree_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]         beats_clamped;

  function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W-1:0] b,
                                   input logic signed [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  config_binary_tree_adder #(
    .P             (P),
    .INPUTS_AMOUNT (INPUTS_AMOUNT)
  ) u_tree (
    .in_data         (in_data),
    .halvedPrecision (halved_q),
    .sum             (tree_sum)
  );

  assign tree_ext      = ACC_W'(tree_sum);
  assign acc_sum       = acc_q + tree_ext;
  assign beats_clamped = (cfg_beats > CNT_W'(MAX_BEATS)) ? CNT_W'(MAX_BEATS) : cfg_beats;

  assign cfg_ready    = (state_q == IDLE);
  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = (state_q == RESULT);
  assign busy         = (state_q != IDLE);
  assign out_data     = acc_q;
  assign out_overflow = ovf_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    beats_d  = beats_q;
    halved_d = halved_q;
    ovf_d    = ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            halved_d = cfg_halved;
            beats_d  = beats_clamped;
            acc_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            state_d  = (beats_clamped != '0) ? ACCUM : RESULT;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_d = acc_sum;
            ovf_d = ovf_q | add_ovf(acc_q, tree_ext, acc_sum);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == beats_q) state_d = RESULT;
          end
        end
        RESULT: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      beats_q  <= '0;
      halved_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      beats_q  <= beats_d;
      halved_q <= halved_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_tree_adder_accum_ctrl.sv
// Directed bench: two controller instances (32-bit and 20-bit accumulators)
// share one stimulus stream; expected sums are hand-computed constants.
module tb_tree_adder_accum_ctrl;

  typedef logic [7:0][15:0] lanes_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_halved = 1'b0;
  logic [8:0]  cfg_beats = '0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  lanes_t      in_data = '0;
  logic        out_ready = 1'b1;

  logic               cfg_ready, in_ready, out_valid, out_overflow, busy;
  logic signed [31:0] out_data;
  logic               cfg_ready20, in_ready20, out_valid20, out_overflow20, busy20;
  logic signed [19:0] out_data20;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tree_adder_accum_ctrl #(.P(16), .INPUTS_AMOUNT(8), .ACC_W(32), .MAX_BEATS(256)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_halved(cfg_halved), .cfg_beats(cfg_beats), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .busy(busy)
  );

  tree_adder_accum_ctrl #(.P(16), .INPUTS_AMOUNT(8), .ACC_W(20), .MAX_BEATS(256)) dut20 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready20),
    .cfg_halved(cfg_halved), .cfg_beats(cfg_beats), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready20), .in_data(in_data),
    .out_valid(out_valid20), .out_ready(out_ready), .out_data(out_data20),
    .out_overflow(out_overflow20), .busy(busy20)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic lanes_t pack_full(input int v[8]);
    lanes_t r;
    for (int i = 0; i < 8; i++) r[i] = 16'(v[i]);
    return r;
  endfunction

  function automatic lanes_t pack_half(input int hi[8], input int lo[8]);
    lanes_t r;
    for (int i = 0; i < 8; i++) r[i] = {8'(hi[i]), 8'(lo[i])};
    return r;
  endfunction

  function automatic lanes_t splat(input int v);
    lanes_t r;
    for (int i = 0; i < 8; i++) r[i] = 16'(v);
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_job(input logic h, input int k);
    check_val("cfg_ready_idle", longint'(cfg_ready), 1);
    cfg_valid  = 1'b1;
    cfg_halved = h;
    cfg_beats  = 9'(k);
    tick();
    cfg_valid  = 1'b0;
    cfg_halved = 1'b0;
    cfg_beats  = '0;
  endtask

  task automatic send_beat(input lanes_t d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check_val("in_ready_timeout", longint'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input longint exp, input logic exp_ovf);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_valid"}, longint'(out_valid), 1);
    check_val({tag, "_data"}, longint'(out_data), exp);
    check_val({tag, "_ovf"}, longint'(out_overflow), longint'(exp_ovf));
  endtask

  initial begin
    lanes_t a;
    int hi[8], lo[8];
    a = '0;

    // Reset state
    #2;
    check_val("rst_out_valid", longint'(out_valid), 0);
    check_val("rst_in_ready", longint'(in_ready), 0);
    check_val("rst_busy", longint'(busy), 0);
    check_val("rst_cfg_ready", longint'(cfg_ready), 1);
    check_val("rst_out_data", longint'(out_data), 0);
    check_val("rst_ovf", longint'(out_overflow), 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: full precision, K=2, exact latency
    a = pack_full('{1, 2, 3, 4, 5, 6, 7, 8});
    start_job(1'b0, 2);
    check_val("t1_busy", longint'(busy), 1);
    send_beat(a);
    check_val("t1_no_early_valid", longint'(out_valid), 0);
    send_beat(a);
    check_val("t1_latency_valid", longint'(out_valid), 1);
    check_val("t1_data", longint'(out_data), 72);
    check_val("t1_ovf", longint'(out_overflow), 0);
    tick();
    check_val("t1_idle_valid", longint'(out_valid), 0);
    check_val("t1_idle_busy", longint'(busy), 0);

    // 2: halved precision, positive then negative pairs
    for (int i = 0; i < 8; i++) begin
      hi[i] = 2 * i + 1;
      lo[i] = 2 * i + 2;
    end
    start_job(1'b1, 1);
    send_beat(pack_half(hi, lo));
    expect_result("t2_pos", 136, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      hi[i] = -(2 * i + 1);
      lo[i] = -(2 * i + 2);
    end
    start_job(1'b1, 1);
    send_beat(pack_half(hi, lo));
    expect_result("t2_neg", -136, 1'b0);
    tick();

    // 3: K=3 with input gaps and a stalled consumer
    out_ready = 1'b0;
    start_job(1'b0, 3);
    send_beat(pack_full('{1, -2, 3, -4, 5, -6, 7, -8}));
    tick(); tick();
    check_val("t3_gap_busy", longint'(busy), 1);
    send_beat(pack_full('{127, -128, 0, 1, 0, 0, 0, 0}));
    tick(); tick();
    send_beat(splat(10));
    cfg_valid  = 1'b1;
    cfg_halved = 1'b1;
    cfg_beats  = 9'd5;
    in_valid   = 1'b1;
    in_data    = splat(1000);
    for (int c = 0; c < 4; c++) begin
      check_val("t3_hold_valid", longint'(out_valid), 1);
      check_val("t3_hold_data", longint'(out_data), 76);
      check_val("t3_hold_busy", longint'(busy), 1);
      tick();
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    check_val("t3_after_hold", longint'(out_data), 76);
    out_ready = 1'b1;
    tick();
    check_val("t3_released", longint'(out_valid), 0);

    // 4: 20-bit accumulator wrap and sticky overflow
    start_job(1'b0, 2);
    send_beat(splat(32767));
    send_beat(splat(32767));
    check_val("t4_k2_valid20", longint'(out_valid20), 1);
    check_val("t4_k2_data20", longint'(out_data20), 524272);
    check_val("t4_k2_ovf20", longint'(out_overflow20), 0);
    tick();
    start_job(1'b0, 3);
    for (int b = 0; b < 3; b++) send_beat(splat(32767));
    check_val("t4_k3_data20", longint'(out_data20), -262168);
    check_val("t4_k3_ovf20", longint'(out_overflow20), 1);
    check_val("t4_k3_data32", longint'(out_data), 786408);
    check_val("t4_k3_ovf32", longint'(out_overflow), 0);
    tick();
    start_job(1'b0, 1);
    send_beat(splat(1));
    check_val("t4_next_ovf20", longint'(out_overflow20), 0);
    check_val("t4_next_data20", longint'(out_data20), 8);
    tick();

    // 5: clear beats a simultaneous beat handshake
    start_job(1'b0, 4);
    send_beat(splat(3));
    in_data  = splat(5);
    in_valid = 1'b1;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check_val("t5_idle_busy", longint'(busy), 0);
    check_val("t5_idle_in_ready", longint'(in_ready), 0);
    check_val("t5_acc_zeroed", longint'(out_data), 0);
    for (int c = 0; c < 3; c++) begin
      check_val("t5_no_valid", longint'(out_valid), 0);
      tick();
    end
    clear     = 1'b1;
    cfg_valid = 1'b1;
    cfg_beats = 9'd1;
    tick();
    clear     = 1'b0;
    cfg_valid = 1'b0;
    check_val("t5_clear_idle_cfg", longint'(busy), 0);
    start_job(1'b0, 1);
    send_beat(splat(1));
    expect_result("t5_new", 8, 1'b0);
    tick();

    // 6: K=0, then async reset mid-job
    start_job(1'b0, 0);
    check_val("t6_k0_valid", longint'(out_valid), 1);
    check_val("t6_k0_data", longint'(out_data), 0);
    tick();
    start_job(1'b0, 2);
    send_beat(splat(2));
    #2 rst = 1'b1;
    #1;
    check_val("t6_rst_busy", longint'(busy), 0);
    check_val("t6_rst_in_ready", longint'(in_ready), 0);
    check_val("t6_rst_valid", longint'(out_valid), 0);
    check_val("t6_rst_data", longint'(out_data), 0);
    check_val("t6_rst_cfg_ready", longint'(cfg_ready), 1);
    tick();
    rst = 1'b0;
    tick();
    start_job(1'b0, 1);
    send_beat(splat(2));
    expect_result("t6_after_rst", 16, 1'b0);
    tick();

    // Beat count above MAX_BEATS clamps to 256 beats of all-1 lanes
    start_job(1'b0, 300);
    for (int b = 0; b < 255; b++) send_beat(splat(1));
    check_val("clamp_not_done", longint'(out_valid), 0);
    send_beat(splat(1));
    check_val("clamp_valid", longint'(out_valid), 1);
    check_val("clamp_data", longint'(out_data), 2048);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
